// File: rtl/qaoa_df_region_ctrl_if.sv
// Handshake bundle between the region controller and its environment.
// master: region consumer plus the dataflow processes; slave: the controller.
interface qaoa_df_region_ctrl_if #(
  parameter int PROC_NUM = 2
);
  logic                ap_start;
  logic                ap_ready;
  logic                ap_done;
  logic                ap_idle;
  logic                ap_continue;
  logic [PROC_NUM-1:0] proc_start;
  logic [PROC_NUM-1:0] proc_ready;
  logic [PROC_NUM-1:0] proc_done;
  logic [PROC_NUM-1:0] proc_continue;
  logic                dl_detect_out;
  logic [PROC_NUM-1:0] dl_proc_vec;

  modport master (
    output ap_start, ap_continue, proc_ready, proc_done,
    input  ap_ready, ap_done, ap_idle, proc_start, proc_continue,
           dl_detect_out, dl_proc_vec
  );

  modport slave (
    input  ap_start, ap_continue, proc_ready, proc_done,
    output ap_ready, ap_done, ap_idle, proc_start, proc_continue,
           dl_detect_out, dl_proc_vec
  );
endinterface

// File: rtl/qaoa_df_region_ctrl.sv
// Start fan-out / ready+done join for the qaoa_kernel dataflow region (ap_ctrl_chain).
// Optional stall watchdog enabled by defining QAOA_DF_WATCHDOG_EN.
//
// state    | meaning
// ST_IDLE  | region idle, waiting for ap_start
// ST_RUN   | processes started; collecting ready and done
// ST_SYNC  | all processes done, holding ap_done until ap_continue
module qaoa_df_region_ctrl #(
  parameter int PROC_NUM = 2,
  parameter int WD_LIMIT = 1000,
  parameter int WD_W     = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  qaoa_df_region_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_SYNC} state_t;

  localparam logic [PROC_NUM-1:0] ALL_ONES = '1;

  if (PROC_NUM < 1 || WD_LIMIT < 1 || WD_W < 1) begin : g_bad_cfg
    $error("qaoa_df_region_ctrl: PROC_NUM, WD_LIMIT and WD_W must all be >= 1");
  end

  state_t              state;
  logic [PROC_NUM-1:0] ready_reg;
  logic [PROC_NUM-1:0] done_reg;
  logic [PROC_NUM-1:0] acc;
  logic [PROC_NUM-1:0] ready_nxt;
  logic [PROC_NUM-1:0] done_nxt;
  logic                run;
  logic                sync;
  logic                all_done;

  always_comb begin
    run       = (state == ST_RUN);
    sync      = (state == ST_SYNC);
    acc       = run ? (~ready_reg & bus.proc_ready) : '0;
    ready_nxt = ready_reg | acc;
    done_nxt  = done_reg | bus.proc_done;
    all_done  = &done_nxt;
  end

  // Join outputs are combinational so a same-cycle ready/done costs no latency.
  assign bus.proc_start    = run ? ~ready_reg : '0;
  assign bus.ap_idle       = (state == ST_IDLE);
  assign bus.ap_ready      = run && (&ready_nxt) && !(&ready_reg);
  assign bus.ap_done       = (run && all_done) || sync;
  assign bus.proc_continue = (bus.ap_done && bus.ap_continue) ? ALL_ONES : '0;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state     <= ST_IDLE;
      ready_reg <= '0;
      done_reg  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.ap_start) begin
            ready_reg <= '0;
            done_reg  <= '0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          ready_reg <= ready_nxt;
          done_reg  <= done_nxt;
          if (all_done) begin
            state <= bus.ap_continue ? ST_IDLE : ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (bus.ap_continue) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef QAOA_DF_WATCHDOG_EN
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(WD_LIMIT);
  localparam logic [WD_W-1:0] WD_ONE = {{(WD_W-1){1'b0}}, 1'b1};

  logic [WD_W-1:0]     wd_cnt;
  logic                dl_detect_q;
  logic [PROC_NUM-1:0] dl_proc_q;
  logic                progress;

  assign progress = (|acc) || (run && |(done_nxt & ~done_reg));

  // A stall in ST_SYNC belongs to the consumer, so the count only runs in ST_RUN.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wd_cnt      <= '0;
      dl_detect_q <= 1'b0;
      dl_proc_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: wd_cnt <= '0;
        ST_RUN: begin
          if (progress) begin
            wd_cnt <= '0;
          end else if (wd_cnt != WD_MAX) begin
            wd_cnt <= wd_cnt + WD_ONE;
          end
        end
        default: wd_cnt <= wd_cnt;
      endcase
      if (wd_cnt == WD_MAX && !dl_detect_q) begin
        dl_detect_q <= 1'b1;
        dl_proc_q   <= ~done_reg;
      end
    end
  end

  assign bus.dl_detect_out = dl_detect_q;
  assign bus.dl_proc_vec   = dl_proc_q;
`else
  assign bus.dl_detect_out = 1'b0;
  assign bus.dl_proc_vec   = '0;
`endif

endmodule
